// File: rtl/wb_arbiter_if.sv
// Wishbone arbiter request/grant bundle.
// master modport: requester side; slave modport: arbiter side.
interface wb_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int OW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] cyc_i;
    logic [NUM_MASTERS-1:0] lock_i;
    logic                   ack_i;
    logic [NUM_MASTERS-1:0] gnt_o;
    logic [OW-1:0]          owner_o;
    logic                   busy_o;
    logic                   timeout_o;

    modport master (
        output cyc_i, lock_i, ack_i,
        input  gnt_o, owner_o, busy_o, timeout_o
    );

    modport slave (
        input  cyc_i, lock_i, ack_i,
        output gnt_o, owner_o, busy_o, timeout_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin wishbone bus arbiter with lock support.
// Optional watchdog release enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rstn_i,
    wb_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } state_t;

    state_t        state;
    logic [OW-1:0] lp;
    logic [OW-1:0] win;
    logic          any_req;
    logic          own_cyc;
    logic          own_lock;
    logic          expire;

    assign any_req  = |bus.cyc_i;
    assign own_cyc  = bus.cyc_i[bus.owner_o];
    assign own_lock = bus.lock_i[bus.owner_o];

    // First requester after the last owner, wrapping around.
    always_comb begin
        logic found;
        int   j;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = int'(lp) + k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && bus.cyc_i[j]) begin
                win   = OW'(j);
                found = 1'b1;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt;

    assign expire = (state != IDLE) &&
                    (cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (any_req) cnt <= '0;
        end else if (bus.ack_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    logic unused_ack;

    assign unused_ack = bus.ack_i;
    assign expire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            lp            <= OW'(NUM_MASTERS - 1);
            bus.gnt_o     <= '0;
            bus.owner_o   <= '0;
            bus.busy_o    <= 1'b0;
            bus.timeout_o <= 1'b0;
        end else begin
            bus.timeout_o <= expire;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.gnt_o   <= ONE << win;
                        bus.owner_o <= win;
                        bus.busy_o  <= 1'b1;
                        lp          <= win;
                        state       <= GRANT;
                    end
                end
                GRANT, LOCKED: begin
                    if (expire || (!own_cyc && !own_lock)) begin
                        bus.gnt_o   <= '0;
                        bus.owner_o <= '0;
                        bus.busy_o  <= 1'b0;
                        state       <= IDLE;
                    end else if (own_cyc) begin
                        state <= GRANT;
                    end else begin
                        state <= LOCKED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter (2- and 4-master instances).
// Timeout steps compile in when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rstn_i = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_MASTERS(2)) ifa ();
    wb_arbiter_if #(.NUM_MASTERS(4)) ifb ();

    wb_arbiter #(
        .NUM_MASTERS(2),
        .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk),
        .rstn_i(rstn_i),
        .bus(ifa)
    );

    wb_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk),
        .rstn_i(rstn_i),
        .bus(ifb)
    );

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check_out();
        exp_t       e;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
        e = sb.pop_front();
        if (e.sel) begin
            g = ifb.gnt_o;
            o = ifb.owner_o;
            b = ifb.busy_o;
            t = ifb.timeout_o;
        end else begin
            g = {2'b00, ifa.gnt_o};
            o = {1'b0, ifa.owner_o};
            b = ifa.busy_o;
            t = ifa.timeout_o;
        end
        n_total++;
        assert ({g, o, b, t} === {e.g, e.o, e.b, e.t})
            n_pass++;
        else
            $error("FAIL %s: got gnt=%b own=%0d busy=%b to=%b, exp gnt=%b own=%0d busy=%b to=%b",
                   e.tag, g, o, b, t, e.g, e.o, e.b, e.t);
    endtask

    task automatic push(input bit sel, input logic [3:0] g,
                        input logic [1:0] o, input logic b,
                        input logic t, input string tag);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.g   = g;
        e.o   = o;
        e.b   = b;
        e.t   = t;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        ifa.cyc_i  = '0;
        ifa.lock_i = '0;
        ifa.ack_i  = 1'b0;
        ifb.cyc_i  = '0;
        ifb.lock_i = '0;
        ifb.ack_i  = 1'b0;
    endtask

    // Drive 2-master DUT for one cycle, check state after the edge.
    task automatic ta(input logic [1:0] c, input logic [1:0] l,
                      input logic a, input logic [1:0] g,
                      input logic o, input logic b, input logic t,
                      input string tag);
        ifa.cyc_i  = c;
        ifa.lock_i = l;
        ifa.ack_i  = a;
        ifb.cyc_i  = '0;
        ifb.lock_i = '0;
        push(1'b0, {2'b00, g}, {1'b0, o}, b, t, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic tb4(input logic [3:0] c, input logic [3:0] g,
                       input logic [1:0] o, input logic b,
                       input string tag);
        ifa.cyc_i  = '0;
        ifa.lock_i = '0;
        ifb.cyc_i  = c;
        ifb.lock_i = '0;
        ifb.ack_i  = 1'b1;
        push(1'b1, g, o, b, 1'b0, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        push(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, "rst_a");
        check_out();
        push(1'b1, 4'b0, 2'd0, 1'b0, 1'b0, "rst_b");
        check_out();
        rstn_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Basic grant and release
        ta(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "g1");
        for (int i = 0; i < 4; i++)
            ta(2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "g1_hold");
        ta(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "g1_rel");
        ta(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "g1_idle");

        // Alternating round robin with both masters requesting
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                ta(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "rr_m0");
            ta(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rr_dead0");
            for (int i = 0; i < 3; i++)
                ta(2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "rr_m1");
            ta(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rr_dead1");
        end

        // Lock holds the bus through a cyc gap
        do_reset();
        ta(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "lk_grant");
        ta(2'b11, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "lk_busy");
        for (int i = 0; i < 4; i++)
            ta(2'b10, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, "lk_hold");
        ta(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "lk_rel");
        ta(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "lk_next");

        // Asynchronous reset mid-transaction
        ta(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "pre_rst");
        #3;
        rstn_i = 1'b0;
        #1;
        push(1'b0, 4'b0, 2'd0, 1'b0, 1'b0, "async_rst");
        check_out();
        #2;
        rstn_i = 1'b1;
        ta(2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, "rst_regrant");
        ta(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "rst_rel");

        // Four masters: pointer wraps from last owner
        do_reset();
        tb4(4'b0001, 4'b0001, 2'd0, 1'b1, "m4_g0");
        tb4(4'b0000, 4'b0000, 2'd0, 1'b0, "m4_r0");
        tb4(4'b0010, 4'b0010, 2'd1, 1'b1, "m4_g1");
        tb4(4'b0000, 4'b0000, 2'd0, 1'b0, "m4_r1");
        tb4(4'b1001, 4'b1000, 2'd3, 1'b1, "m4_rr3");
        tb4(4'b0000, 4'b0000, 2'd0, 1'b0, "m4_r3");
        tb4(4'b1001, 4'b0001, 2'd0, 1'b1, "m4_wrap0");
        tb4(4'b0000, 4'b0000, 2'd0, 1'b0, "m4_r4");

        do_reset();
`ifdef WB_ARB_TIMEOUT_EN
        ta(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, "to_grant");
        for (int k = 1; k <= 8; k++)
            ta(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, "to_hold");
        ta(2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "to_fire");
        ta(2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, "to_rr");
        for (int k = 1; k <= 13; k++)
            ta(2'b11, 2'b00, (k == 5), 2'b10, 1'b1, 1'b1, 1'b0, "to_ack");
        ta(2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "to_fire2");
        ta(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "to_clear");
`else
        ta(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, "nt_grant");
        for (int k = 0; k < 20; k++)
            ta(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, "nt_hold");
        ta(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "nt_rel");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin bus arbiter that shares one wishbone interconnect port between NUM_MASTERS masters (load unit, store unit, fetch unit).
- Drives the wb_gnt that each master waits on.
- Drives the owner index the interconnect uses to mux master signals onto the shared port.
- Honours wb_lock so that a master can keep the bus across back-to-back transactions.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 2..8.
- TIMEOUT_CYCLES, 255, watchdog limit used only when WB_ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  input  1  clock.
- rstn_i  input  1  reset; asynchronous, active-low.
- cyc_i  input  NUM_MASTERS  per-master wb_cyc (bus request).
- lock_i  input  NUM_MASTERS  per-master wb_lock.
- ack_i  input  1  wb_ack from the shared slave side; used by the timeout feature only.
- gnt_o  output  NUM_MASTERS  one-hot grant; routed to each master's wb_gnt.
- owner_o  output  $clog2(NUM_MASTERS)  index of the current owner, for the interconnect mux.
- busy_o  output  1  bus currently granted.
- timeout_o  output  1  one-cycle pulse on a forced release; tied 0 without WB_ARB_TIMEOUT_EN.

Behaviour:
- Reset values: gnt_o=0, owner_o=0, busy_o=0, timeout_o=0, state=IDLE, last-owner pointer lp=NUM_MASTERS-1 (so master 0 wins the first arbitration).
- All outputs are registered; no combinational path exists from cyc_i or lock_i to gnt_o.
- States: IDLE, GRANT, LOCKED.
- IDLE:
  - If cyc_i≠0, pick the first set bit searching lp+1, lp+2, … modulo NUM_MASTERS.
  - On the next clock: gnt_o=onehot(winner), owner_o=winner, busy_o=1, lp=winner, state=GRANT.
  - Grant latency is 1 cycle from cyc_i assertion in IDLE.
  - If cyc_i=0, remain in IDLE with all outputs 0.
- GRANT:
  - Hold the grant while cyc_i[owner]=1; requests from other masters are ignored.
  - If cyc_i[owner]=0 and lock_i[owner]=1: state=LOCKED, grant held.
  - If cyc_i[owner]=0 and lock_i[owner]=0: next clock gnt_o=0, busy_o=0, state=IDLE.
  - Rearbitration happens in that IDLE cycle, so there is exactly one dead cycle between owners.
  - Release followed by new grant: cycle t cyc drops → t+1 gnt_o=0 → t+2 new gnt_o.
- LOCKED:
  - Grant held while lock_i[owner]=1, regardless of cyc_i[owner].
  - If cyc_i[owner]=1: back to GRANT.
  - If lock_i[owner]=0 and cyc_i[owner]=0: release to IDLE as in GRANT.
  - lock_i of non-owners is ignored in every state.
- Fairness:
  - lp is updated only when a grant is issued.
  - A master that releases and immediately re-requests loses to any other requester.
  - If it is the only requester, it wins again after the dead cycle.
- Simultaneous requests in IDLE: round-robin order from lp+1 decides; no fixed priority except after reset.
- Owner drops cyc_i in the same cycle another master raises it: normal release path; the new master is granted at t+2.
- Reset mid-transaction: all outputs drop asynchronously; the arbiter restarts in IDLE with lp=NUM_MASTERS-1.
- Masters must not drive stb while gnt_o=0. The arbiter does not check this.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on every grant and on every cycle with ack_i=1.
  - It increments every cycle in GRANT or LOCKED without ack_i.
  - When the count reaches TIMEOUT_CYCLES, the grant is forcibly released the next clock, exactly like a normal release (gnt_o=0, state=IDLE).
  - timeout_o pulses high for that one cycle.
  - The starved owner keeps requesting; it is rearbitrated normally and placed last in round-robin order.
- When undefined: no counter logic is present, timeout_o is constant 0, and a grant is held indefinitely.

Test Plan:
- Reset, then cyc_i=01 at cycle 0 → gnt_o=01, owner_o=0, busy_o=1 at cycle 1; cyc_i=00 at cycle 5 → gnt_o=00 at cycle 6.
- Reset, then cyc_i=11 held continuously, each owner drops cyc for 1 cycle after 3 cycles of ownership → gnt_o alternates 01,00,10,00,01,…; never two consecutive grants to the same master.
- Master 0 owns with lock_i[0]=1, drops cyc_i[0] for 4 cycles while cyc_i[1]=1 → gnt_o stays 01; lock_i[0]→0 → gnt_o=00 next cycle, then gnt_o=10.
- NUM_MASTERS=4, lp=1, cyc_i=1001 in IDLE → master 3 granted (owner_o=3), not master 0.
- rstn_i asserted while gnt_o=10 → gnt_o=00, busy_o=0 immediately; after release with cyc_i=10, master 1 is granted at cycle 1.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: owner holds cyc with no ack_i → timeout_o=1 and gnt_o=0 exactly 9 cycles after the grant; one ack_i at cycle 5 → the count restarts and no timeout occurs before cycle 14.
